// File: rtl/l1i_refill_unit_pkg.sv
// Shared fetch-side definitions: refill FSM states and the default widths
// used by the L1I cache and its refill unit.
package l1i_refill_unit_pkg;

   localparam int ADDR_W     = 64;
   localparam int LINE_W     = 512;
   localparam int OFFSET_W   = 6;
   localparam int BEAT_W     = 128;
   localparam int PID_W      = 20;
   localparam int TID_W      = 16;
   localparam int INST_CNT_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_COLLECT = 2'd2,
      ST_UPDATE  = 2'd3
   } refill_state_e;

   // A single-beat line still needs a one-bit counter.
   function automatic int beat_cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/l1i_refill_unit_line_assembler.sv
// Collects memory response beats into a cache line, beat 0 in the most
// significant slot, and flags the beat that completes the line.
module l1i_refill_unit_line_assembler
   import l1i_refill_unit_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_W,
   parameter int BEAT_WIDTH = BEAT_W
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  clear_i,
   input  logic                  beat_valid_i,
   input  logic [BEAT_WIDTH-1:0] beat_data_i,
   output logic [LINE_WIDTH-1:0] line_o,
   output logic                  done_o
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W = beat_cnt_width(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (beat_valid_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign done_o = beat_valid_i && (cnt_q == LAST_BEAT);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_slot
         logic [BEAT_WIDTH-1:0] slot_q, slot_d;

         always_comb begin
            slot_d = slot_q;
            if (beat_valid_i && (cnt_q == CNT_W'(gi))) begin
               slot_d = beat_data_i;
            end
         end

         always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
               slot_q <= '0;
            end else begin
               slot_q <= slot_d;
            end
         end

         assign line_o[LINE_WIDTH-1-gi*BEAT_WIDTH -: BEAT_WIDTH] = slot_q;
      end
   endgenerate

endmodule

// File: rtl/l1i_refill_unit.sv
// L1I miss responder: captures one miss, issues a line-aligned read, gathers
// the returned beats and emits a single-cycle cache update with the metadata.
module l1i_refill_unit
   import l1i_refill_unit_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = ADDR_W,
   parameter int LINE_WIDTH      = LINE_W,
   parameter int OFFSET_WIDTH    = OFFSET_W,
   parameter int BEAT_WIDTH      = BEAT_W,
   parameter int PID_WIDTH       = PID_W,
   parameter int TID_WIDTH       = TID_W,
   parameter int INST_ID_WIDTH   = INST_CNT_W
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     cacheMiss_i,
   input  logic [ADDRESS_WIDTH-1:0] missedAddress_i,
   input  logic [INST_ID_WIDTH-1:0] missedInstMajorId_i,
   input  logic [PID_WIDTH-1:0]     missedPid_i,
   input  logic [TID_WIDTH-1:0]     missedTid_i,
   output logic                     busy_o,
   output logic                     memReqValid_o,
   input  logic                     memReqReady_i,
   output logic [ADDRESS_WIDTH-1:0] memReqAddress_o,
   input  logic                     memRespValid_i,
   input  logic [BEAT_WIDTH-1:0]    memRespData_i,
   output logic                     cacheUpdate_o,
   output logic [ADDRESS_WIDTH-1:0] cacheUpdateAddress_o,
   output logic [LINE_WIDTH-1:0]    cacheUpdateLine_o,
   output logic [PID_WIDTH-1:0]     cacheUpdatePid_o,
   output logic [TID_WIDTH-1:0]     cacheUpdateTid_o,
   output logic [INST_ID_WIDTH-1:0] missedInstMajorId_o
);

   localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
      {{(ADDRESS_WIDTH-OFFSET_WIDTH){1'b0}}, {OFFSET_WIDTH{1'b1}}};

   refill_state_e              state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [INST_ID_WIDTH-1:0]   maj_id_q, maj_id_d;
   logic [PID_WIDTH-1:0]       pid_q, pid_d;
   logic [TID_WIDTH-1:0]       tid_q, tid_d;
   logic                       req_accept;
   logic                       beat_valid;
   logic                       line_done;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      maj_id_d   = maj_id_q;
      pid_d      = pid_q;
      tid_d      = tid_q;
      req_accept = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cacheMiss_i) begin
               addr_d   = missedAddress_i & ~OFFSET_MASK;
               maj_id_d = missedInstMajorId_i;
               pid_d    = missedPid_i;
               tid_d    = missedTid_i;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (memReqReady_i) begin
               req_accept = 1'b1;
               state_d    = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (line_done) begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         maj_id_q <= '0;
         pid_q    <= '0;
         tid_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         maj_id_q <= maj_id_d;
         pid_q    <= pid_d;
         tid_q    <= tid_d;
      end
   end

   // Beats arriving in any other state are dropped here.
   assign beat_valid = memRespValid_i && (state_q == ST_COLLECT);

   l1i_refill_unit_line_assembler #(
      .LINE_WIDTH (LINE_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH)
   ) u_line_assembler (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .clear_i      (req_accept),
      .beat_valid_i (beat_valid),
      .beat_data_i  (memRespData_i),
      .line_o       (cacheUpdateLine_o),
      .done_o       (line_done)
   );

   assign busy_o               = (state_q != ST_IDLE);
   assign memReqValid_o        = (state_q == ST_REQ);
   assign memReqAddress_o      = addr_q;
   assign cacheUpdate_o        = (state_q == ST_UPDATE);
   assign cacheUpdateAddress_o = addr_q;
   assign cacheUpdatePid_o     = pid_q;
   assign cacheUpdateTid_o     = tid_q;
   assign missedInstMajorId_o  = maj_id_q;

endmodule
